// File: rtl/intdiv_otfconv.sv
// intdiv_otfconv: serial on-the-fly conversion of SD2 quotient digits
// (MSD first) into a WIDTH+1 bit two's-complement result, keeping the
// Q / QM = Q-1 register pair so no carry-propagate add is ever needed.
module intdiv_otfconv #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             negate,
   input  logic             digit_valid,
   input  logic [1:0]       digit,
   output logic             digit_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result
);

   localparam int unsigned RW       = WIDTH + 1;
   localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e          state_q;
   logic [RW-1:0]   q_q;
   logic [RW-1:0]   qm_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;
   logic [RW-1:0]   result_q;

   logic            raw_pos_c;
   logic            raw_neg_c;
   logic            dig_pos_c;
   logic            dig_neg_c;
   logic [RW-1:0]   q_sh_c;
   logic [RW-1:0]   qm_sh_c;
   logic [RW-1:0]   q_d;
   logic [RW-1:0]   qm_d;

   // Decode the SD2 digit (01/10 = +1, 11 = -1, 00 = 0), apply the latched negate,
   // and form the next Q/QM pair by selecting between the shifted registers.
   always_comb begin
      raw_pos_c = digit[1] ^ digit[0];
      raw_neg_c = digit[1] & digit[0];
      dig_pos_c = neg_q ? raw_neg_c : raw_pos_c;
      dig_neg_c = neg_q ? raw_pos_c : raw_neg_c;
      q_sh_c    = q_q << 1;
      qm_sh_c   = qm_q << 1;
      q_d       = q_sh_c;
      qm_d      = qm_sh_c | RW'(1);
      if (dig_pos_c) begin
         q_d  = q_sh_c | RW'(1);
         qm_d = q_sh_c;
      end else if (dig_neg_c) begin
         q_d  = qm_sh_c | RW'(1);
         qm_d = qm_sh_c;
      end
   end

   // Control FSM, Q/QM accumulation and registered handshake/result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         q_q      <= '0;
         qm_q     <= '1;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_ACCUM;
                  q_q     <= '0;
                  qm_q    <= '1;
                  cnt_q   <= '0;
                  neg_q   <= negate;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (start) begin
                  // restart: any digit offered alongside start is dropped
                  q_q   <= '0;
                  qm_q  <= '1;
                  cnt_q <= '0;
                  neg_q <= negate;
               end else if (digit_valid) begin
                  q_q   <= q_d;
                  qm_q  <= qm_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CNT_LAST) begin
                     state_q  <= ST_DONE;
                     result_q <= q_d;
                     done_q   <= 1'b1;
                     ready_q  <= 1'b0;
                     busy_q   <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_q <= ST_ACCUM;
                  q_q     <= '0;
                  qm_q    <= '1;
                  cnt_q   <= '0;
                  neg_q   <= negate;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign digit_ready = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;

endmodule

// File: tb/tb_intdiv_otfconv.sv
// Scoreboard bench for intdiv_otfconv at WIDTH=4: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_intdiv_otfconv;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         negate = 1'b0;
   logic         digit_valid = 1'b0;
   logic [1:0]   digit = 2'b00;
   logic         digit_ready;
   logic         busy;
   logic         done;
   logic [W:0]   result;

   int           errors = 0;
   int           checks = 0;
   logic [W:0]   sb[$];

   intdiv_otfconv #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .negate      (negate),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_ready (digit_ready),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            logic [W:0] e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e));
            check("busy_in_done", 32'(busy), 32'(0));
            check("ready_in_done", 32'(digit_ready), 32'(0));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic neg, input logic vld, input logic [1:0] d);
      start       = 1'b1;
      negate      = neg;
      digit_valid = vld;
      digit       = d;
      tick();
      start       = 1'b0;
      negate      = 1'b0;
      digit_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] d, input int gap);
      for (int g = 0; g < gap; g++) begin
         digit_valid = 1'b0;
         tick();
         check("ready_in_gap", 32'(digit_ready), 32'(1));
         check("no_early_done", 32'(done), 32'(0));
      end
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic finish_conv;
      // currently in the DONE cycle; step back to IDLE and confirm a single pulse
      tick();
      check("done_single", 32'(done), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
      check("sb_drained", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      // reset state
      #3;
      check("rst_result", 32'(result), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ready", 32'(digit_ready), 32'(0));
      #10 rst_n = 1'b1;
      tick();

      // basic mixed digits: +7
      sb.push_back(5'b00111);
      do_start(1'b0, 1'b0, 2'b00);
      check("start_ready", 32'(digit_ready), 32'(1));
      check("start_busy", 32'(busy), 32'(1));
      send(2'b01, 0); send(2'b00, 0); send(2'b11, 0); send(2'b01, 0);
      check("done_after_last", 32'(done), 32'(1));
      finish_conv();

      // all -1: -15
      sb.push_back(5'b10001);
      do_start(1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) send(2'b11, 0);
      finish_conv();

      // alternate +1 code: +15
      sb.push_back(5'b01111);
      do_start(1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) send(2'b10, 0);
      finish_conv();

      // negate with stalls: -7
      sb.push_back(5'b11001);
      do_start(1'b1, 1'b0, 2'b00);
      send(2'b01, 0); send(2'b00, 1); send(2'b11, 2); send(2'b01, 3);
      finish_conv();

      // restart mid-conversion, digit offered with start is dropped
      do_start(1'b0, 1'b0, 2'b00);
      send(2'b01, 0); send(2'b01, 0);
      sb.push_back(5'b00001);
      do_start(1'b0, 1'b1, 2'b01);
      check("restart_ready", 32'(digit_ready), 32'(1));
      send(2'b00, 0); send(2'b00, 0); send(2'b00, 0); send(2'b01, 0);
      finish_conv();

      // back-to-back: start in the DONE cycle
      sb.push_back(5'b00111);
      do_start(1'b0, 1'b0, 2'b00);
      send(2'b01, 0); send(2'b00, 0); send(2'b11, 0); send(2'b01, 0);
      sb.push_back(5'b11000);
      do_start(1'b0, 1'b0, 2'b00);
      check("b2b_ready", 32'(digit_ready), 32'(1));
      check("b2b_hold", 32'(result), 32'(5'b00111));
      send(2'b11, 0); send(2'b00, 0);
      check("b2b_hold_mid", 32'(result), 32'(5'b00111));
      send(2'b00, 0); send(2'b00, 0);
      finish_conv();

      // asynchronous reset mid-conversion
      do_start(1'b0, 1'b0, 2'b00);
      send(2'b01, 0); send(2'b01, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_result", 32'(result), 32'(0));
      check("arst_done", 32'(done), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_ready", 32'(digit_ready), 32'(0));
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_idle", 32'(busy), 32'(0));
      sb.push_back(5'b01000);
      do_start(1'b0, 1'b0, 2'b00);
      send(2'b01, 0); send(2'b00, 0); send(2'b00, 0); send(2'b00, 0);
      finish_conv();

      tick(); tick();
      check("final_sb_empty", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
